snake_dir_ctrl: RTL and testbench

Converts the keyboard event stream (8-bit make-code plus one-cycle `keyPressed` strobe from the PS/2 receiver) into snake game control. It decodes direction, pause and restart keys and rejects illegal 180° reversals. Accepted turns are buffered in a small FIFO so fast key sequences are not lost, and one queued turn is released per game tick. It sits between the PS/2 receiver and the game-logic/movement engine, all in the 100 MHz `clk` domain.

---
 rtl/snake_dir_ctrl.sv | 147 ++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// Turns PS/2 make-code events into snake control: decodes direction,
// pause and restart keys, rejects 180-degree reversals and duplicates,
// queues accepted turns in a small FIFO and releases one turn per game tick.
//
// Ports
//   clk          system clock (100 MHz)
//   rst          synchronous active-high reset
//   scancode     make-code, sampled only while keyPressed=1
//   keyPressed   one-cycle key event strobe
//   tick         one-cycle game step strobe
//   dir          current movement direction (00 up, 01 right, 10 down, 11 left)
//   move         one-cycle step strobe (tick while not paused)
//   paused       pause state level
//   restart      one-cycle restart strobe
//   key_dropped  one-cycle strobe: direction key rejected
//   q_count      number of queued turns
//
// Handshake: there is no backpressure. Every input strobe is a one-cycle
// valid with implicit ready=1; every output strobe is registered and
// appears exactly one cycle after its causing input strobe.
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] INIT_DIR = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                scancode,
  input  logic                      keyPressed,
  input  logic                      tick,
  output logic [1:0]                dir,
  output logic                      move,
  output logic                      paused,
  output logic                      restart,
  output logic                      key_dropped,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Turn FIFO storage and pointers; pointers wrap naturally at QDEPTH
  // because QDEPTH is a power of two.
  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Decoded key event
  logic       is_dir;
  logic       is_pause;
  logic       is_restart;
  logic [1:0] cand;

  always_comb begin
    is_dir     = 1'b0;
    is_pause   = 1'b0;
    is_restart = 1'b0;
    cand       = 2'b00;
    if (keyPressed) begin
      case (scancode)
        8'h1D, 8'h75: begin is_dir = 1'b1; cand = 2'b00; end
        8'h23, 8'h74: begin is_dir = 1'b1; cand = 2'b01; end
        8'h1B, 8'h72: begin is_dir = 1'b1; cand = 2'b10; end
        8'h1C, 8'h6B: begin is_dir = 1'b1; cand = 2'b11; end
        8'h29:        is_pause   = 1'b1;
        8'h5A:        is_restart = 1'b1;
        default:      ;
      endcase
    end
  end

  // Reference direction: the turn the snake will be heading in after all
  // queued turns are applied. Evaluated on pre-pop contents.
  logic [PW-1:0] newest_ptr;
  logic [1:0]    ref_dir;
  logic          q_empty;
  logic          q_full;
  logic          do_move;
  logic          do_pop;
  logic          accept;
  logic          drop;

  always_comb begin
    newest_ptr = wr_ptr - PW'(1);
    q_empty    = (q_count == '0);
    q_full     = (q_count == CW'(QDEPTH));
    ref_dir    = q_empty ? dir : mem[newest_ptr];
    do_move    = tick && !paused;
    do_pop     = do_move && !q_empty;
    // A full FIFO still accepts when a pop frees a slot in the same cycle.
    accept     = is_dir && !paused
                 && (cand != ref_dir)
                 && (cand != (ref_dir ^ 2'b10))
                 && (!q_full || do_pop);
    drop       = is_dir && !accept;
  end

  // FIFO storage write; contents need no reset since q_count gates reads.
  always_ff @(posedge clk) begin
    if (!rst && !is_restart && accept) begin
      mem[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir         <= INIT_DIR;
      move        <= 1'b0;
      paused      <= 1'b0;
      restart     <= 1'b0;
      key_dropped <= 1'b0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (is_restart) begin
      // Restart overrides every other event in the same cycle, tick included.
      dir         <= INIT_DIR;
      move        <= 1'b0;
      paused      <= 1'b0;
      restart     <= 1'b1;
      key_dropped <= 1'b0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      move        <= do_move;
      restart     <= 1'b0;
      key_dropped <= drop;
      if (is_pause) begin
        paused <= ~paused;
      end
      if (do_pop) begin
        dir    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({accept, do_pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl
// Directed scenarios plus randomized traffic for snake_dir_ctrl, checked
// against a queue-based behavioural model of the key/turn rules.
module tb_snake_dir_ctrl;

  localparam int         QDEPTH   = 4;
  localparam logic [1:0] INIT_DIR = 2'b01;
  localparam int         CW       = $clog2(QDEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [7:0]    scancode;
  logic          keyPressed;
  logic          tick;
  logic [1:0]    dir;
  logic          move;
  logic          paused;
  logic          restart;
  logic          key_dropped;
  logic [CW-1:0] q_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(INIT_DIR)) dut (
    .clk(clk), .rst(rst), .scancode(scancode), .keyPressed(keyPressed),
    .tick(tick), .dir(dir), .move(move), .paused(paused), .restart(restart),
    .key_dropped(key_dropped), .q_count(q_count)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Kinds: 0 ignored, 1 direction, 2 pause, 3 restart
  logic [1:0] exp_q[$];
  logic [1:0] m_dir;
  logic       m_paused;
  logic       m_move;
  logic       m_restart;
  logic       m_drop;

  function automatic int decode(input logic [7:0] code, output logic [1:0] d);
    d = 2'b00;
    if (code == 8'h1D || code == 8'h75) begin d = 2'b00; return 1; end
    if (code == 8'h23 || code == 8'h74) begin d = 2'b01; return 1; end
    if (code == 8'h1B || code == 8'h72) begin d = 2'b10; return 1; end
    if (code == 8'h1C || code == 8'h6B) begin d = 2'b11; return 1; end
    if (code == 8'h29) return 2;
    if (code == 8'h5A) return 3;
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic kp, input logic [7:0] code,
                            input logic tk);
    logic [1:0] c;
    logic [1:0] heading;
    int         kind;
    logic       will_pop;
    logic       do_push;
    m_move = 1'b0; m_restart = 1'b0; m_drop = 1'b0; do_push = 1'b0;
    kind = kp ? decode(code, c) : 0;
    if (r || kind == 3) begin
      exp_q.delete();
      m_dir = INIT_DIR;
      m_paused = 1'b0;
      m_restart = !r;
      return;
    end
    will_pop = tk && !m_paused && exp_q.size() > 0;
    if (kind == 1) begin
      heading = (exp_q.size() > 0) ? exp_q[$] : m_dir;
      if (m_paused || c == heading || c == (heading ^ 2'b10) ||
          (exp_q.size() == QDEPTH && !will_pop))
        m_drop = 1'b1;
      else
        do_push = 1'b1;
    end
    if (tk && !m_paused) begin
      m_move = 1'b1;
      if (exp_q.size() > 0) m_dir = exp_q.pop_front();
    end
    if (do_push) exp_q.push_back(c);
    if (kind == 2) m_paused = !m_paused;
  endtask

  // ---------------- driver ----------------
  // Inputs change #1 after the active edge; outputs are sampled at the same
  // point, so after step() they show the response to the applied strobes.
  task automatic step(input logic kp, input logic [7:0] code, input logic tk);
    logic r;
    r = rst;
    keyPressed = kp; scancode = code; tick = tk;
    @(posedge clk); #1;
    keyPressed = 1'b0; tick = 1'b0; scancode = 8'($urandom);
    model_step(r, kp, code, tk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (dir !== INIT_DIR) begin errors++; $display("FAIL reset_dir got=%b exp=%b", dir, INIT_DIR); end
    checks++; if (move !== 1'b0) begin errors++; $display("FAIL reset_move got=%b exp=0", move); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got=%b exp=0", paused); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b exp=0", restart); end
    checks++; if (key_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", key_dropped); end
    checks++; if (q_count !== 0) begin errors++; $display("FAIL reset_qcount got=%0d exp=0", q_count); end
  endtask

  task automatic test_basic_turns();
    do_reset();
    step(1'b1, 8'h72, 1'b0);
    checks++; if (q_count !== 1) begin errors++; $display("FAIL basic_q1 got=%0d exp=1", q_count); end
    step(1'b1, 8'h1C, 1'b0);
    checks++; if (q_count !== 2) begin errors++; $display("FAIL basic_q2 got=%0d exp=2", q_count); end
    checks++; if (dir !== 2'b01) begin errors++; $display("FAIL basic_dir_held got=%b exp=01", dir); end
    step(1'b0, 8'h00, 1'b1);
    checks++; if (move !== 1'b1 || dir !== 2'b10 || q_count !== 1) begin errors++;
      $display("FAIL basic_tick1 move=%b dir=%b q=%0d exp 1/10/1", move, dir, q_count); end
    step(1'b0, 8'h00, 1'b1);
    checks++; if (move !== 1'b1 || dir !== 2'b11 || q_count !== 0) begin errors++;
      $display("FAIL basic_tick2 move=%b dir=%b q=%0d exp 1/11/0", move, dir, q_count); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (move !== 1'b0) begin errors++; $display("FAIL basic_move_width got=%b exp=0", move); end
  endtask

  task automatic test_reversal();
    do_reset();
    step(1'b1, 8'h6B, 1'b0);
    checks++; if (key_dropped !== 1'b1 || q_count !== 0) begin errors++;
      $display("FAIL rev_left drop=%b q=%0d exp 1/0", key_dropped, q_count); end
    step(1'b1, 8'h75, 1'b0);
    checks++; if (key_dropped !== 1'b0 || q_count !== 1) begin errors++;
      $display("FAIL rev_up drop=%b q=%0d exp 0/1", key_dropped, q_count); end
    step(1'b1, 8'h72, 1'b0);
    checks++; if (key_dropped !== 1'b1 || q_count !== 1) begin errors++;
      $display("FAIL rev_down drop=%b q=%0d exp 1/1", key_dropped, q_count); end
    step(1'b1, 8'h1D, 1'b0);
    checks++; if (key_dropped !== 1'b1 || q_count !== 1) begin errors++;
      $display("FAIL rev_dup drop=%b q=%0d exp 1/1", key_dropped, q_count); end
  endtask

  task automatic test_fifo_full();
    logic [1:0] exp_dirs[4];
    exp_dirs = '{2'b01, 2'b00, 2'b01, 2'b00};
    do_reset();
    step(1'b1, 8'h75, 1'b0);
    step(1'b1, 8'h74, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    checks++; if (q_count !== QDEPTH) begin errors++; $display("FAIL full_fill got=%0d exp=%0d", q_count, QDEPTH); end
    step(1'b1, 8'h75, 1'b0);
    checks++; if (key_dropped !== 1'b1 || q_count !== QDEPTH) begin errors++;
      $display("FAIL full_drop drop=%b q=%0d exp 1/%0d", key_dropped, q_count, QDEPTH); end
    step(1'b1, 8'h75, 1'b1);
    checks++; if (key_dropped !== 1'b0 || q_count !== QDEPTH || move !== 1'b1 || dir !== 2'b00) begin errors++;
      $display("FAIL full_pushpop drop=%b q=%0d move=%b dir=%b exp 0/%0d/1/00",
               key_dropped, q_count, move, dir, QDEPTH); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++; if (dir !== exp_dirs[i] || q_count !== 3 - i) begin errors++;
        $display("FAIL full_drain%0d dir=%b q=%0d exp %b/%0d", i, dir, q_count, exp_dirs[i], 3 - i); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    step(1'b1, 8'h72, 1'b0);
    step(1'b1, 8'h29, 1'b0);
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on got=%b exp=1", paused); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++; if (move !== 1'b0 || dir !== 2'b01 || q_count !== 1) begin errors++;
        $display("FAIL pause_tick%0d move=%b dir=%b q=%0d exp 0/01/1", i, move, dir, q_count); end
    end
    step(1'b1, 8'h1C, 1'b0);
    checks++; if (key_dropped !== 1'b1 || q_count !== 1) begin errors++;
      $display("FAIL pause_key drop=%b q=%0d exp 1/1", key_dropped, q_count); end
    step(1'b1, 8'h29, 1'b0);
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off got=%b exp=0", paused); end
    step(1'b0, 8'h00, 1'b1);
    checks++; if (move !== 1'b1 || dir !== 2'b10 || q_count !== 0) begin errors++;
      $display("FAIL pause_resume move=%b dir=%b q=%0d exp 1/10/0", move, dir, q_count); end
  endtask

  task automatic test_restart();
    do_reset();
    step(1'b1, 8'h72, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'h29, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    checks++; if (restart !== 1'b1 || move !== 1'b0 || dir !== INIT_DIR || q_count !== 0 || paused !== 1'b0) begin
      errors++; $display("FAIL restart_pulse rs=%b move=%b dir=%b q=%0d p=%b exp 1/0/%b/0/0",
                         restart, move, dir, q_count, paused, INIT_DIR); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_width got=%b exp=0", restart); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 8'h75, 1'b0);
    step(1'b1, 8'h6B, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    checks++; if (move !== 1'b1 || dir !== 2'b11) begin errors++;
      $display("FAIL b2b_move move=%b dir=%b exp 1/11", move, dir); end
    step(1'b1, 8'h23, 1'b1);
    checks++; if (move !== 1'b1 || key_dropped !== 1'b1) begin errors++;
      $display("FAIL b2b_drop move=%b drop=%b exp 1/1", move, key_dropped); end
    step(1'b1, 8'h23, 1'b0);
    checks++; if (key_dropped !== 1'b1 || move !== 1'b0) begin errors++;
      $display("FAIL b2b_drop2 drop=%b move=%b exp 1/0", key_dropped, move); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 8'h75, 1'b0);
    step(1'b1, 8'h6B, 1'b0);
    step(1'b1, 8'h72, 1'b0);
    step(1'b1, 8'h29, 1'b0);
    checks++; if (q_count !== 3 || paused !== 1'b1) begin errors++;
      $display("FAIL midrst_setup q=%0d p=%b exp 3/1", q_count, paused); end
    step(1'b1, 8'h1D, 1'b1);
    rst = 1'b1;
    step(1'b1, 8'h5A, 1'b1);
    rst = 1'b0;
    checks++; if (dir !== INIT_DIR || move !== 1'b0 || paused !== 1'b0 || restart !== 1'b0 ||
                  key_dropped !== 1'b0 || q_count !== 0) begin errors++;
      $display("FAIL midrst_outputs dir=%b mv=%b p=%b rs=%b kd=%b q=%0d", dir, move, paused,
               restart, key_dropped, q_count); end
    step(1'b1, 8'h15, 1'b0);
    checks++; if (dir !== INIT_DIR || move !== 1'b0 || paused !== 1'b0 || restart !== 1'b0 ||
                  key_dropped !== 1'b0 || q_count !== 0) begin errors++;
      $display("FAIL unmapped dir=%b mv=%b p=%b rs=%b kd=%b q=%0d", dir, move, paused,
               restart, key_dropped, q_count); end
  endtask

  task automatic test_random();
    logic [7:0] dir_codes[8];
    logic [7:0] code;
    logic       kp;
    logic       tk;
    int         r;
    dir_codes = '{8'h1D, 8'h75, 8'h23, 8'h74, 8'h1B, 8'h72, 8'h1C, 8'h6B};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      code = dir_codes[$urandom_range(0, 7)];
      else if (r < 73) code = 8'h29;
      else if (r < 76) code = 8'h5A;
      else             code = 8'($urandom);
      kp  = ($urandom_range(0, 99) < 60);
      tk  = ($urandom_range(0, 99) < 30);
      rst = ($urandom_range(0, 499) == 0);
      step(kp, code, tk);
      checks++;
      if (dir !== m_dir || move !== m_move || paused !== m_paused || restart !== m_restart ||
          key_dropped !== m_drop || q_count !== CW'(exp_q.size())) begin
        errors++;
        $display("FAIL random_cycle%0d got dir=%b mv=%b p=%b rs=%b kd=%b q=%0d exp dir=%b mv=%b p=%b rs=%b kd=%b q=%0d",
                 n, dir, move, paused, restart, key_dropped, q_count,
                 m_dir, m_move, m_paused, m_restart, m_drop, exp_q.size());
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; keyPressed = 1'b0; tick = 1'b0; scancode = 8'h00;
    m_dir = INIT_DIR; m_paused = 1'b0; m_move = 1'b0; m_restart = 1'b0; m_drop = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic_turns();
    test_reversal();
    test_fifo_full();
    test_pause();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
